shift_sequencer: RTL and testbench

- Multi-cycle shift/rotate execution unit for the CPU ALU.
- Performs SHR, SHRA, SHL, ROR and ROL over several clocks, STEP bits per clock, using one small shift stage rather than a full barrel shifter.
- The control unit starts it with a start/busy/done handshake and reads the result from `result`.

---
 rtl/shift_sequencer_pkg.sv | 11 +
 rtl/shift_sequencer_step.sv | 25 ++
 rtl/shift_sequencer.sv | 94 +++++++++
 tb/tb_shift_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: op/state encodings, default sizes and op decode shared by the shift sequencer
package shift_sequencer_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int STEP_DEF = 1;
    typedef enum logic [2:0] {SHR_OP = 3'd0, SHRA_OP = 3'd1, SHL_OP = 3'd2, ROR_OP = 3'd3, ROL_OP = 3'd4} op_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
    // reserved encodings execute as a logical right shift
    function automatic op_t decode_op(input logic [2:0] op);
        return op > 3'd4 ? SHR_OP : op_t'(op);
    endfunction
endpackage

// File: rtl/shift_sequencer_step.sv
// shift_step: combinational shift/rotate of d by k (0..STEP) according to op
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP = STEP_DEF,
    parameter int KW = $clog2(STEP + 1)
) (
    input  logic [2:0]        op,
    input  logic [KW-1:0]     k,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    logic [2*DATA_W-1:0] rr, rl;
    logic [DATA_W-1:0] sra;
    always_comb begin
        rr = {d, d} >> k;
        rl = {d, d} << k;
        sra = $signed(d) >>> k;
        q = op == SHRA_OP ? sra :
            op == SHL_OP  ? d << k :
            op == ROR_OP  ? rr[DATA_W-1:0] :
            op == ROL_OP  ? rl[2*DATA_W-1:DATA_W] : d >> k;
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate unit, STEP bits per clock with start/busy/done handshake.
// Define SHIFT_SEQ_FULLAMT_EN to saturate shifts whose full amount reaches DATA_W.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP = STEP_DEF,
    parameter int AMT_W = $clog2(DATA_W)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] shift_amount,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              illegal_op
);
    localparam int KW = $clog2(STEP + 1);
    state_t state;
    op_t op_r;
    logic [DATA_W-1:0] work, nxt, sat_val;
    logic [AMT_W-1:0] rem, amt;
    logic [KW-1:0] k;
    logic sat, sat_in;
    assign amt = shift_amount[AMT_W-1:0];
    assign k = rem < AMT_W'(STEP) ? rem[KW-1:0] : KW'(STEP);
    assign sat_val = op_r == SHRA_OP ? {DATA_W{work[DATA_W-1]}} : '0;
`ifdef SHIFT_SEQ_FULLAMT_EN
    // rotates keep mod-DATA_W behaviour; plain shifts collapse to a single saturating step
    assign sat_in = shift_amount >= DATA_W && !(decode_op(op) inside {ROR_OP, ROL_OP});
`else
    logic unused_hi;
    assign unused_hi = ^shift_amount[DATA_W-1:AMT_W];
    assign sat_in = 1'b0;
`endif
    shift_step #(.DATA_W(DATA_W), .STEP(STEP)) u_step (
        .op(op_r),
        .k(k),
        .d(work),
        .q(nxt)
    );
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            illegal_op <= 1'b0;
            rem <= '0;
            work <= '0;
            op_r <= SHR_OP;
            sat <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    work <= data_in;
                    op_r <= decode_op(op);
                    rem <= amt;
                    sat <= sat_in;
                    illegal_op <= illegal_op | (op > 3'd4);
                    if (amt == '0 && !sat_in) begin
                        state <= S_DONE;
                        done <= 1'b1;
                        result <= data_in;
                    end else begin
                        state <= S_SHIFT;
                        busy <= 1'b1;
                    end
                end
                S_SHIFT: if (abort) begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                end else begin
                    work <= sat ? sat_val : nxt;
                    rem <= sat ? '0 : rem - AMT_W'(k);
                    if (sat || rem == AMT_W'(k)) begin
                        state <= S_DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        result <= sat ? sat_val : nxt;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of a STEP=1 and a STEP=4 shift_sequencer
module tb_shift_sequencer;
    logic clock = 1'b0;
    logic clear, start0, start4, abort;
    logic [2:0] op;
    logic [31:0] data_in, shift_amount;
    logic busy0, done0, illegal0, busy4, done4, illegal4;
    logic [31:0] result0, result4;
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    shift_sequencer #(.DATA_W(32), .STEP(1)) u0 (
        .clock(clock), .clear(clear), .start(start0), .op(op), .data_in(data_in),
        .shift_amount(shift_amount), .abort(abort), .busy(busy0), .done(done0),
        .result(result0), .illegal_op(illegal0)
    );
    shift_sequencer #(.DATA_W(32), .STEP(4)) u4 (
        .clock(clock), .clear(clear), .start(start4), .op(op), .data_in(data_in),
        .shift_amount(shift_amount), .abort(abort), .busy(busy4), .done(done4),
        .result(result4), .illegal_op(illegal4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // cycles counts edges after acceptance until done is seen; -1 means done never came
    task automatic run(input string tag, input bit s4, input logic [2:0] o, input logic [31:0] d,
                       input logic [31:0] amt, input logic [31:0] exp_r, input int exp_c,
                       input int ab = -1, input int pk = -1, input int cl = -1);
        int cyc;
        @(negedge clock);
        start0 = !s4;
        start4 = s4;
        op = o;
        data_in = d;
        shift_amount = amt;
        abort = (ab == 0);
        @(posedge clock);
        @(negedge clock);
        start0 = 1'b0;
        start4 = 1'b0;
        abort = 1'b0;
        op = 3'd0;
        data_in = 32'hDEAD_BEEF;
        shift_amount = 32'd3;
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (s4 ? done4 : done0) begin
                cyc = i;
                break;
            end
            start0 = !s4 && (i + 1 == pk);
            start4 = s4 && (i + 1 == pk);
            abort = (i + 1 == ab);
            clear = !(i + 1 == cl);
            @(posedge clock);
            @(negedge clock);
        end
        start0 = 1'b0;
        start4 = 1'b0;
        abort = 1'b0;
        clear = 1'b1;
        check({tag, "_cycles"}, cyc, exp_c);
        check({tag, "_result"}, s4 ? result4 : result0, exp_r);
        check({tag, "_busy"}, {31'd0, s4 ? busy4 : busy0}, 32'd0);
        @(negedge clock);
    endtask

    initial begin
        clear = 1'b0;
        start0 = 1'b0;
        start4 = 1'b0;
        abort = 1'b0;
        op = 3'd0;
        data_in = 32'd0;
        shift_amount = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_result", result0, 32'd0);
        check("rst_illegal", {31'd0, illegal0}, 32'd0);
        clear = 1'b1;
        run("shra1", 1'b0, 3'd1, 32'hFFFF_FFFA, 32'd1, 32'hFFFF_FFFD, 1);
        run("shra0", 1'b0, 3'd1, 32'hFFFF_FFFA, 32'd0, 32'hFFFF_FFFA, 0);
        run("shr31", 1'b0, 3'd0, 32'h8000_0000, 32'd31, 32'h0000_0001, 31);
        run("rol4", 1'b0, 3'd4, 32'h8000_0001, 32'd4, 32'h0000_0018, 4);
        run("s4_shl9", 1'b1, 3'd2, 32'h0000_0001, 32'd9, 32'h0000_0200, 3);
        run("s4_ror6", 1'b1, 3'd3, 32'h0000_0003, 32'd6, 32'h0C00_0000, 2);
        run("poke_busy", 1'b0, 3'd2, 32'h0000_0001, 32'd5, 32'h0000_0020, 5, -1, 2);
        run("abort", 1'b0, 3'd2, 32'h0000_0001, 32'd5, 32'h0000_0020, -1, 2);
        run("start_abort", 1'b0, 3'd0, 32'h0000_0100, 32'd4, 32'h0000_0010, 4, 0);
        check("illegal_clean", {31'd0, illegal0}, 32'd0);
        run("reserved", 1'b0, 3'd6, 32'h0000_0010, 32'd4, 32'h0000_0001, 4);
        check("illegal_set", {31'd0, illegal0}, 32'd1);
        run("shl1", 1'b0, 3'd2, 32'h0000_0003, 32'd1, 32'h0000_0006, 1);
        check("illegal_sticky", {31'd0, illegal0}, 32'd1);
`ifdef SHIFT_SEQ_FULLAMT_EN
        run("shra40", 1'b0, 3'd1, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1);
`else
        run("shra40", 1'b0, 3'd1, 32'h8000_0000, 32'd40, 32'hFF80_0000, 8);
`endif
        run("rst_mid", 1'b0, 3'd2, 32'h0000_0001, 32'd20, 32'h0000_0000, -1, -1, -1, 5);
        check("rst_mid_illegal", {31'd0, illegal0}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
